// File: rtl/neuron_pkg.sv
// Shared types and Q8.8 fixed-point constants for the neuron sequencer.
package neuron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_MAC    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int          FRAC_BITS = 8;
  localparam int          DATA_W    = 16;
  localparam logic [15:0] Q_MAX     = 16'h7FFF;
  localparam logic [15:0] Q_MIN     = 16'h8000;
  localparam int          ACC_W_DEF = 40;

endpackage

// File: rtl/neuron_mac.sv
// Signed Q8.8 multiply-accumulate with clear, saturating Q8.8 result and threshold compare.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] thresh,
  output logic        [DATA_W-1:0] sat_next,
  output logic                     ge_next
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [ACC_W-1:0]    thr_ext;
  logic signed [ACC_W-1:0]    max_v;
  logic signed [ACC_W-1:0]    min_v;

  assign prod     = x * w;
  assign acc_next = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign shifted  = acc_next >>> FRAC_BITS;
  // threshold moved from Q8.8 into the Q16.16 accumulator scale
  assign thr_ext  = {{(ACC_W-DATA_W-FRAC_BITS){thresh[DATA_W-1]}}, thresh, {FRAC_BITS{1'b0}}};
  assign max_v    = {{(ACC_W-DATA_W){1'b0}}, Q_MAX};
  assign min_v    = {{(ACC_W-DATA_W){1'b1}}, Q_MIN};
  assign ge_next  = (acc_next >= thr_ext);

  always_comb begin
    sat_next = shifted[DATA_W-1:0];
    if (shifted > max_v)
      sat_next = Q_MAX;
    else if (shifted < min_v)
      sat_next = Q_MIN;
  end

  always_ff @(posedge clk) begin
    if (rst || clr)
      acc <= '0;
    else if (en)
      acc <= acc_next;
  end

endmodule

// File: rtl/neuron_sequencer.sv
// Streams N_INPUTS samples against ROM weights, accumulates, and fires against a threshold.
module neuron_sequencer
  import neuron_pkg::*;
#(
  parameter int N_INPUTS  = 10,
  parameter int BASE_ADDR = 1,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] thresh,
  output logic        busy,
  output logic        done,
  output logic        y,
  output logic [15:0] result,
  input  logic        x_valid,
  output logic        x_ready,
  input  logic [15:0] x_data,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_dout
);

  state_t      state;
  logic [15:0] idx;
  logic [15:0] x_reg;
  logic [15:0] thresh_q;
  logic [15:0] sat_next;
  logic        ge_next;
  logic        mac_clr;
  logic        mac_en;

  assign mac_clr = (state == ST_IDLE) && start;
  assign mac_en  = (state == ST_MAC);

  neuron_mac #(.ACC_W(ACC_W)) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr      (mac_clr),
    .en       (mac_en),
    .x        (x_reg),
    .w        (rom_dout),
    .thresh   (thresh_q),
    .sat_next (sat_next),
    .ge_next  (ge_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      y        <= 1'b0;
      result   <= '0;
      x_ready  <= 1'b0;
      rom_addr <= 16'(BASE_ADDR);
      idx      <= '0;
      x_reg    <= '0;
      thresh_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx      <= '0;
            rom_addr <= 16'(BASE_ADDR);
            thresh_q <= thresh;
            busy     <= 1'b1;
            x_ready  <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (x_valid) begin
            x_reg   <= x_data;
            x_ready <= 1'b0;
            state   <= ST_MAC;
          end
        end
        ST_MAC: begin
          idx      <= idx + 16'd1;
          rom_addr <= rom_addr + 16'd1;
          // outputs captured from the final accumulate so they are valid with done
          if (idx == 16'(N_INPUTS - 1)) begin
            result <= sat_next;
            y      <= ge_next;
            done   <= 1'b1;
            state  <= ST_FINISH;
          end else begin
            x_ready <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/neuron_sequencer.md
NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

Interface
REQ-001 Parameter N_INPUTS, default 10, number of weights/inputs per evaluation; legal range 1..65535-BASE_ADDR.
REQ-002 Parameter BASE_ADDR, default 1, ROM address of weight 0; weight i is at BASE_ADDR+i.
REQ-003 Parameter ACC_W, default 40, signed accumulator width; must be >= 32+ceil(log2(N_INPUTS)).
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 start  in  1  request one neuron evaluation; sampled only in IDLE.
REQ-007 thresh  in  16  signed Q8.8 firing threshold; latched when start is accepted.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse; y and result valid in that cycle and held until the next accepted start.
REQ-010 y  out  1  neuron output: 1 if weighted sum >= thresh, else 0.
REQ-011 result  out  16  signed Q8.8 weighted sum, saturated.
REQ-012 x_valid / x_ready / x_data  in / out / in (16)  input sample stream, signed Q8.8, transfer when x_valid and x_ready are both high.
REQ-013 rom_addr  out  16  registered weight-ROM address.
REQ-014 rom_dout  in  16  signed Q8.8 weight; ROM read latency is exactly 1 cycle (data for the address sampled at edge k is valid after edge k).

Function
REQ-015 States: IDLE, LOAD, MAC, FINISH.
REQ-016 IDLE: on start, clear acc to 0, set idx to 0, set rom_addr to BASE_ADDR, latch thresh, and go to LOAD; otherwise stay in IDLE.
REQ-017 LOAD: x_ready=1; rom_addr holds BASE_ADDR+idx; on handshake latch x_data and go to MAC; if x_valid is low, stay in LOAD indefinitely.
REQ-018 x_ready shall be 0 in every state except LOAD.
REQ-019 MAC: acc += sext(x * rom_dout), a full 32-bit signed product in Q16.16; increment idx and rom_addr.
REQ-020 MAC exit: go to FINISH if idx was N_INPUTS-1; otherwise go to LOAD.
REQ-021 FINISH (one cycle):
 - y = (acc >= sext(thresh)<<8);
 - result = acc>>>8, clamped to [0x8000, 0x7FFF];
 - done=1;
 - next state IDLE.
REQ-022 Latency: with x_valid held high and start sampled in cycle 0, done is high in cycle 2*N_INPUTS+1; each cycle x_valid is low while in LOAD adds exactly one cycle.
REQ-023 start while busy is ignored and has no effect on the run in progress.
REQ-024 start in the same cycle as done is not accepted; it is accepted no earlier than the following cycle, in IDLE.
REQ-025 The accumulator never wraps for legal ACC_W; saturation occurs only at the 16-bit result.
REQ-026 Exact-threshold equality yields y=1.
REQ-027 rom_addr changes only on the IDLE->LOAD transition and in MAC; it never changes in LOAD.

Reset
REQ-028 On rst:
 - state=IDLE;
 - busy=0, done=0, y=0, result=0, x_ready=0;
 - rom_addr=BASE_ADDR, acc=0, idx=0.
REQ-029 rst asserted mid-run aborts the evaluation with no done pulse; after rst, the first start begins a fresh run from weight 0.

Structure
REQ-030 Shared package neuron_pkg holds the state enum, Q8.8 constants (FRAC_BITS=8, DATA_W=16, Q_MAX=16'h7FFF, Q_MIN=16'h8000), and the default ACC_W.
REQ-031 One sub-module, neuron_mac: signed multiply, accumulate with clear, and saturating Q8.8 output conversion.

Verification
The bench uses a 1-cycle ROM model with weights at addresses 1..10 = 0x0000, 0x0000, 0x0300, 0x0400, 0x0500, 0x0600, 0x0000, 0x0000, 0x0000, 0x0000.
REQ-032 All x=0x0100, thresh=0x1000, x_valid always high -> result=0x1200, y=1, done in cycle 21.
REQ-033 Same inputs, thresh=0x1200 -> y=1 (equality); thresh=0x1201 -> y=0.
REQ-034 All x=0x7FFF -> result=0x7FFF (saturated), y=1; all x=0x8000 -> result=0x8000, y=0.
REQ-035 x_valid low for 5 cycles before input 3 -> result unchanged, done in cycle 26; x_ready and rom_addr are stable during the stall.
REQ-036 start pulsed in cycle 7 of a run -> ignored and the result is unchanged; rst in cycle 9 -> no done, all outputs at reset values; next start produces result=0x1200 normally.
